// File: rtl/score_pkg.sv
// Purpose : shared types and constants for the score keeper.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package score_pkg;

    // Listed in service priority order, highest first.
    typedef enum logic [1:0] {
        EV_GHOST,
        EV_POWER,
        EV_PELLET,
        EV_FRUIT
    } event_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int SCORE_W = 16;
    localparam int SUM_W   = SCORE_W + 1;
    localparam int FRUIT_W = 12;

    // Ghost combo index 0..3 selects 200/400/800/1600.
    localparam int                 COMBO_W   = 2;
    localparam logic [COMBO_W-1:0] COMBO_MAX = 2'd3;

    localparam int unsigned DEF_SCORE_MAX       = 9999;
    localparam int unsigned DEF_PELLET_PTS      = 10;
    localparam int unsigned DEF_POWER_PTS       = 50;
    localparam int unsigned DEF_GHOST_BASE      = 200;
    localparam int unsigned DEF_EXTRA_LIFE_AT   = 5000;
    localparam int unsigned DEF_HIGH_SCORE_INIT = 0;

    // Add and clamp to the display ceiling; the sum is formed one bit wider
    // so the compare never sees a wrapped value.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b,
        input logic [SUM_W-1:0]   limit
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > limit) begin
            return limit[SCORE_W-1:0];
        end
        return sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_keeper_event_pending.sv
// Purpose : per-source 2-bit pending-event counter with overflow detect.
// Latency : count updates on the edge that samples inc/dec; pending is registered.
// Backpressure: none upstream; a pulse that finds the counter full is dropped and flagged on ovf.
//
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (new event pulse),
//        dec (event serviced this cycle, only while pending), pending (count != 0),
//        ovf (combinational, high in the cycle a pulse is dropped).
module event_pending #(
    parameter logic [1:0] CNT_MAX        = 2'd3,
    // When set, a pulse is refused whenever the counter is full, even if the
    // same cycle services an entry (used by the fruit source, whose value
    // register is only one deep).
    parameter bit         DROP_WHEN_BUSY = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic pending,
    output logic ovf
);

    logic [1:0] cnt;
    logic       full;
    logic       accept;

    assign full    = (cnt == CNT_MAX);
    // A service in the same cycle frees a slot, so a full counter can still
    // take the pulse unless this source refuses pulses while busy.
    assign accept  = inc && (!full || (dec && !DROP_WHEN_BUSY));
    assign ovf     = inc && !accept;
    assign pending = (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
        end else begin
            case ({accept, dec})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Purpose : accumulates game events into a saturating score, tracks high score and extra life.
// Latency : event pulse at edge N is pending after N; score moves at N+1 when uncontended; high_score one edge later.
// Backpressure: none; up to 3 queued events per source (1 for fruit), extra pulses dropped and flagged on sticky overflow.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   game_start          pulse; enters CLEAR and wipes per-game state
//   pellet_eaten, power_eaten, ghost_eaten, fruit_eaten
//                       single-cycle event pulses
//   fruit_value[11:0]   points for the fruit, sampled with fruit_eaten
//   score[15:0]         current score, never above SCORE_MAX
//   high_score[15:0]    best score since reset
//   extra_life          one-cycle pulse when the score first reaches EXTRA_LIFE_AT in a game
//   overflow            sticky; some event pulse was dropped
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned SCORE_MAX       = DEF_SCORE_MAX,
    parameter int unsigned PELLET_PTS      = DEF_PELLET_PTS,
    parameter int unsigned POWER_PTS       = DEF_POWER_PTS,
    parameter int unsigned GHOST_BASE      = DEF_GHOST_BASE,
    parameter int unsigned EXTRA_LIFE_AT   = DEF_EXTRA_LIFE_AT,
    parameter int unsigned HIGH_SCORE_INIT = DEF_HIGH_SCORE_INIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               pellet_eaten,
    input  logic               power_eaten,
    input  logic               ghost_eaten,
    input  logic               fruit_eaten,
    input  logic [FRUIT_W-1:0] fruit_value,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               extra_life,
    output logic               overflow
);

    localparam logic [SUM_W-1:0]   SUM_LIMIT  = SUM_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] PELLET_V   = SCORE_W'(PELLET_PTS);
    localparam logic [SCORE_W-1:0] POWER_V    = SCORE_W'(POWER_PTS);
    localparam logic [SCORE_W-1:0] GHOST_V    = SCORE_W'(GHOST_BASE);
    localparam logic [SCORE_W-1:0] LIFE_V     = SCORE_W'(EXTRA_LIFE_AT);
    localparam logic [SCORE_W-1:0] HIGH_INIT  = SCORE_W'(HIGH_SCORE_INIT);

    state_t             state;
    state_t             state_nxt;
    logic               clr;
    logic               sel_vld;
    event_t             sel;

    logic               ghost_pend;
    logic               power_pend;
    logic               pellet_pend;
    logic               fruit_pend;
    logic [3:0]         ovf_vec;

    logic [COMBO_W-1:0] combo;
    logic [FRUIT_W-1:0] fruit_val;
    logic [SCORE_W-1:0] pts;
    logic [SCORE_W-1:0] score_nxt;
    logic               life_given;
    logic               crosses_life;

    // ------------------------------------------------------------------
    // Pending counters, one per source. Pulses are ignored while the
    // per-game state is being wiped (game_start cycle and CLEAR cycle).
    // ------------------------------------------------------------------
    event_pending #(.CNT_MAX(2'd3), .DROP_WHEN_BUSY(1'b0)) u_ghost (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (ghost_eaten && !clr),
        .dec     (sel_vld && (sel == EV_GHOST)),
        .pending (ghost_pend),
        .ovf     (ovf_vec[0])
    );

    event_pending #(.CNT_MAX(2'd3), .DROP_WHEN_BUSY(1'b0)) u_power (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (power_eaten && !clr),
        .dec     (sel_vld && (sel == EV_POWER)),
        .pending (power_pend),
        .ovf     (ovf_vec[1])
    );

    event_pending #(.CNT_MAX(2'd3), .DROP_WHEN_BUSY(1'b0)) u_pellet (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (pellet_eaten && !clr),
        .dec     (sel_vld && (sel == EV_PELLET)),
        .pending (pellet_pend),
        .ovf     (ovf_vec[2])
    );

    // Fruit has a single value register, so only one fruit may be in flight.
    event_pending #(.CNT_MAX(2'd1), .DROP_WHEN_BUSY(1'b1)) u_fruit (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (fruit_eaten && !clr),
        .dec     (sel_vld && (sel == EV_FRUIT)),
        .pending (fruit_pend),
        .ovf     (ovf_vec[3])
    );

    // ------------------------------------------------------------------
    // Control FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Control FSM: next state, clear strobe and priority service select.
    // The game_start cycle already counts as clearing so no event from it
    // (or any still-queued event) leaks into the new game.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        sel_vld   = 1'b0;
        sel       = EV_GHOST;
        case (state)
            IDLE: begin
                if (game_start) begin
                    state_nxt = CLEAR;
                    clr       = 1'b1;
                end else if (ghost_pend) begin
                    sel_vld = 1'b1;
                    sel     = EV_GHOST;
                end else if (power_pend) begin
                    sel_vld = 1'b1;
                    sel     = EV_POWER;
                end else if (pellet_pend) begin
                    sel_vld = 1'b1;
                    sel     = EV_PELLET;
                end else if (fruit_pend) begin
                    sel_vld = 1'b1;
                    sel     = EV_FRUIT;
                end
            end
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = game_start ? CLEAR : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Points for the selected event and the clamped next score.
    // ------------------------------------------------------------------
    always_comb begin
        pts = '0;
        case (sel)
            EV_GHOST:  pts = GHOST_V << combo;
            EV_POWER:  pts = POWER_V;
            EV_PELLET: pts = PELLET_V;
            EV_FRUIT:  pts = {{(SCORE_W-FRUIT_W){1'b0}}, fruit_val};
            default:   pts = '0;
        endcase
        score_nxt    = sat_add(score, pts, SUM_LIMIT);
        crosses_life = !life_given && (score < LIFE_V) && (score_nxt >= LIFE_V);
    end

    // ------------------------------------------------------------------
    // Per-game state: score, combo, extra life, overflow, fruit value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            score      <= '0;
            combo      <= '0;
            life_given <= 1'b0;
            extra_life <= 1'b0;
            overflow   <= 1'b0;
            fruit_val  <= '0;
        end else if (clr) begin
            score      <= '0;
            combo      <= '0;
            life_given <= 1'b0;
            extra_life <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            extra_life <= 1'b0;
            if (|ovf_vec) begin
                overflow <= 1'b1;
            end
            // Same acceptance rule as the fruit counter: only while empty.
            if (fruit_eaten && !fruit_pend) begin
                fruit_val <= fruit_value;
            end
            if (sel_vld) begin
                score <= score_nxt;
                if (sel == EV_GHOST && combo != COMBO_MAX) begin
                    combo <= combo + 1'b1;
                end
                if (sel == EV_POWER) begin
                    combo <= '0;
                end
                if (crosses_life) begin
                    extra_life <= 1'b1;
                    life_given <= 1'b1;
                end
            end
        end
    end

    // High score follows the registered score, so it trails by one cycle and
    // survives game_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_score <= HIGH_INIT;
        end else if (score > high_score) begin
            high_score <= score;
        end
    end

endmodule
